// File: rtl/branch_predict_hazard_unit_if.sv
// Control bundle between the pipeline and the branch predict / hazard unit.
// Valid/ready convention: this bundle carries no handshake. Every input is
// sampled on each rising clk edge unless stall is high. Every output is either
// combinational from the current inputs or a registered counter value.
interface branch_predict_hazard_unit_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned PERF_WIDTH = 16
);
  logic                  stall;
  logic                  clear_stats;
  logic [PC_WIDTH-1:0]   IF_PC;
  logic                  IF_predict_taken;
  logic                  ID_Jump;
  logic                  EX_Branch;
  logic [PC_WIDTH-1:0]   EX_PC;
  logic                  EX_taken;
  logic                  EX_pred_taken;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Flush;
  logic [1:0]            redirect_kind;
  logic [PERF_WIDTH-1:0] branch_count;
  logic [PERF_WIDTH-1:0] mispredict_count;

  // Pipeline side: drives the stage information and consumes the decisions.
  modport master (
    output stall, clear_stats, IF_PC, ID_Jump, EX_Branch, EX_PC, EX_taken, EX_pred_taken,
    input  IF_predict_taken, IF_ID_Flush, ID_EX_Flush, redirect_kind,
           branch_count, mispredict_count
  );

  // Unit side.
  modport slave (
    input  stall, clear_stats, IF_PC, ID_Jump, EX_Branch, EX_PC, EX_taken, EX_pred_taken,
    output IF_predict_taken, IF_ID_Flush, ID_EX_Flush, redirect_kind,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_hazard_unit.sv
// Bimodal branch predictor with flush/redirect control.
// A table of saturating counters is read in IF to predict the branch direction.
// The table is trained when a branch resolves in EX. The pipeline is flushed
// only on a misprediction or on a jump decoded in ID. Saturating statistics
// counters track resolved branches and mispredictions.
module branch_predict_hazard_unit #(
  parameter int unsigned PC_WIDTH      = 32,
  parameter int unsigned BHT_ENTRIES   = 16,
  parameter int unsigned BHT_INDEX_LSB = 2,
  parameter int unsigned COUNTER_WIDTH = 2,
  parameter int unsigned COUNTER_INIT  = 1,
  parameter int unsigned PERF_WIDTH    = 16
) (
  input logic clk,
  input logic reset_n,
  branch_predict_hazard_unit_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = COUNTER_WIDTH'(COUNTER_INIT);
  localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [COUNTER_WIDTH-1:0] CTR_MIN  = '0;
  localparam logic [PERF_WIDTH-1:0]    PERF_MAX = '1;

  logic [COUNTER_WIDTH-1:0] bht [BHT_ENTRIES];
  logic [IDX_W-1:0]         if_idx;
  logic [IDX_W-1:0]         ex_idx;
  logic                     resolve;
  logic                     mis;
  logic [PERF_WIDTH-1:0]    branch_cnt;
  logic [PERF_WIDTH-1:0]    mis_cnt;
  logic                     unused_pc_bits;

  // PC bits outside the index field are intentionally ignored. Aliasing between
  // PCs that share an index is accepted because no tag is kept.
  assign unused_pc_bits = ^{bus.IF_PC, bus.EX_PC};

  assign if_idx  = bus.IF_PC[BHT_INDEX_LSB +: IDX_W];
  assign ex_idx  = bus.EX_PC[BHT_INDEX_LSB +: IDX_W];
  // A branch counts as resolved only in a non-stalled cycle. Because of this, a
  // branch that is held in EX by a stall trains the table exactly once.
  assign resolve = bus.EX_Branch && !bus.stall;
  assign mis     = resolve && (bus.EX_taken != bus.EX_pred_taken);

  // The prediction reads the registered table, so a write to the same index in
  // this cycle becomes visible only on the next cycle.
  assign bus.IF_predict_taken = bht[if_idx][COUNTER_WIDTH-1];

  // Flush and redirect priority: a misprediction wins over a jump in ID,
  // because such a jump is on the wrong path.
  always_comb begin
    bus.IF_ID_Flush   = 1'b0;
    bus.ID_EX_Flush   = 1'b0;
    bus.redirect_kind = 2'b00;
    if (mis) begin
      bus.IF_ID_Flush   = 1'b1;
      bus.ID_EX_Flush   = 1'b1;
      bus.redirect_kind = bus.EX_taken ? 2'b10 : 2'b11;
    end else if (bus.ID_Jump && !bus.stall) begin
      bus.IF_ID_Flush   = 1'b1;
      bus.redirect_kind = 2'b01;
    end
  end

  // Train the counter of the resolving branch. Counters saturate at both ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_INIT;
      end
    end else if (resolve) begin
      if (bus.EX_taken) begin
        if (bht[ex_idx] != CTR_MAX) bht[ex_idx] <= bht[ex_idx] + COUNTER_WIDTH'(1);
      end else begin
        if (bht[ex_idx] != CTR_MIN) bht[ex_idx] <= bht[ex_idx] - COUNTER_WIDTH'(1);
      end
    end
  end

  // Statistics. A clear wins over an increment in the same cycle, and the
  // counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt <= '0;
      mis_cnt    <= '0;
    end else if (bus.clear_stats) begin
      branch_cnt <= '0;
      mis_cnt    <= '0;
    end else if (resolve) begin
      if (branch_cnt != PERF_MAX) branch_cnt <= branch_cnt + PERF_WIDTH'(1);
      if (mis && (mis_cnt != PERF_MAX)) mis_cnt <= mis_cnt + PERF_WIDTH'(1);
    end
  end

  assign bus.branch_count     = branch_cnt;
  assign bus.mispredict_count = mis_cnt;
endmodule

// File: tb/tb_branch_predict_hazard_unit.sv
// Directed bench for branch_predict_hazard_unit. It uses a default-parameter
// instance, plus a PERF_WIDTH=4 instance for the aliasing and saturation cases.
module tb_branch_predict_hazard_unit;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  branch_predict_hazard_unit_if #(.PC_WIDTH(32), .PERF_WIDTH(16)) b ();
  branch_predict_hazard_unit_if #(.PC_WIDTH(32), .PERF_WIDTH(4))  s ();

  branch_predict_hazard_unit #(.PERF_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(b)
  );
  branch_predict_hazard_unit #(.PERF_WIDTH(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .bus(s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    b.stall = 0; b.clear_stats = 0; b.IF_PC = 32'h0040_0000; b.ID_Jump = 0;
    b.EX_Branch = 0; b.EX_PC = 0; b.EX_taken = 0; b.EX_pred_taken = 0;
    s.stall = 0; s.clear_stats = 0; s.IF_PC = 0; s.ID_Jump = 0;
    s.EX_Branch = 0; s.EX_PC = 0; s.EX_taken = 0; s.EX_pred_taken = 0;
  endtask

  // driver: present an EX branch on the default instance
  task automatic drive_branch(input logic [31:0] pc, input logic taken, input logic pred,
                              input logic jump, input logic stl);
    b.EX_Branch = 1; b.EX_PC = pc; b.EX_taken = taken; b.EX_pred_taken = pred;
    b.ID_Jump = jump; b.stall = stl;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (b.IF_predict_taken !== 1'b0) begin
      errors++; $display("FAIL reset_predict got %b want 0", b.IF_predict_taken);
    end
    checks++;
    if (b.branch_count !== 16'd0 || b.mispredict_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", b.branch_count, b.mispredict_count);
    end
    checks++;
    if (b.redirect_kind !== 2'b00 || b.IF_ID_Flush !== 1'b0 || b.ID_EX_Flush !== 1'b0) begin
      errors++; $display("FAIL reset_redirect got %b/%b/%b want 00/0/0",
                         b.redirect_kind, b.IF_ID_Flush, b.ID_EX_Flush);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  // Branch at index 4, trained taken three times. The counter goes 01->10->11->11.
  task automatic test_mispredict_train();
    logic       exp_pred [3];
    logic [1:0] exp_rk   [3];
    logic       exp_fl   [3];
    exp_pred = '{1'b0, 1'b1, 1'b1};
    exp_rk   = '{2'b10, 2'b00, 2'b00};
    exp_fl   = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b.IF_PC = 32'h0040_0010;
      drive_branch(32'h0040_0010, 1'b1, exp_pred[i], 1'b0, 1'b0);
      #1;
      checks++;
      if (b.IF_predict_taken !== exp_pred[i]) begin
        errors++; $display("FAIL train_predict[%0d] got %b want %b", i, b.IF_predict_taken, exp_pred[i]);
      end
      checks++;
      if (b.redirect_kind !== exp_rk[i] || b.IF_ID_Flush !== exp_fl[i] || b.ID_EX_Flush !== exp_fl[i]) begin
        errors++; $display("FAIL train_flush[%0d] got %b/%b/%b want %b/%b/%b", i, b.redirect_kind,
                           b.IF_ID_Flush, b.ID_EX_Flush, exp_rk[i], exp_fl[i], exp_fl[i]);
      end
    end
    @(negedge clk);
    b.EX_Branch = 0;
    #1;
    checks++;
    if (b.branch_count !== 16'd3 || b.mispredict_count !== 16'd1) begin
      errors++; $display("FAIL train_counts got %0d/%0d want 3/1", b.branch_count, b.mispredict_count);
    end
    checks++;
    if (b.IF_predict_taken !== 1'b1) begin
      errors++; $display("FAIL train_saturated got %b want 1", b.IF_predict_taken);
    end
  endtask

  // A mispredicted not-taken branch together with a jump in ID. The counter goes 11->10.
  task automatic test_jump_during_mispredict();
    @(negedge clk);
    drive_branch(32'h0040_0010, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (b.redirect_kind !== 2'b11 || b.IF_ID_Flush !== 1'b1 || b.ID_EX_Flush !== 1'b1) begin
      errors++; $display("FAIL jump_mis got %b/%b/%b want 11/1/1",
                         b.redirect_kind, b.IF_ID_Flush, b.ID_EX_Flush);
    end
    @(negedge clk);
    b.EX_Branch = 0; b.ID_Jump = 0;
    #1;
    checks++;
    if (b.branch_count !== 16'd4 || b.mispredict_count !== 16'd2 || b.IF_predict_taken !== 1'b1) begin
      errors++; $display("FAIL jump_mis_state got %0d/%0d/%b want 4/2/1",
                         b.branch_count, b.mispredict_count, b.IF_predict_taken);
    end
  endtask

  // A jump alone. The EX fields hold junk that must have no effect.
  task automatic test_jump_alone();
    @(negedge clk);
    b.ID_Jump = 1; b.EX_Branch = 0; b.EX_PC = 32'h0040_0010; b.EX_taken = 1; b.EX_pred_taken = 0;
    #1;
    checks++;
    if (b.redirect_kind !== 2'b01 || b.IF_ID_Flush !== 1'b1 || b.ID_EX_Flush !== 1'b0) begin
      errors++; $display("FAIL jump_alone got %b/%b/%b want 01/1/0",
                         b.redirect_kind, b.IF_ID_Flush, b.ID_EX_Flush);
    end
    @(negedge clk);
    b.ID_Jump = 0;
    #1;
    checks++;
    if (b.branch_count !== 16'd4 || b.mispredict_count !== 16'd2 || b.IF_predict_taken !== 1'b1) begin
      errors++; $display("FAIL jump_alone_state got %0d/%0d/%b want 4/2/1",
                         b.branch_count, b.mispredict_count, b.IF_predict_taken);
    end
  endtask

  // A mispredict held by a stall for two cycles, then released. The counter goes 10->01.
  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_branch(32'h0040_0010, 1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      checks++;
      if (b.redirect_kind !== 2'b00 || b.IF_ID_Flush !== 1'b0 || b.ID_EX_Flush !== 1'b0) begin
        errors++; $display("FAIL stall_flush[%0d] got %b/%b/%b want 00/0/0", i,
                           b.redirect_kind, b.IF_ID_Flush, b.ID_EX_Flush);
      end
      checks++;
      if (b.branch_count !== 16'd4 || b.mispredict_count !== 16'd2 || b.IF_predict_taken !== 1'b1) begin
        errors++; $display("FAIL stall_state[%0d] got %0d/%0d/%b want 4/2/1", i,
                           b.branch_count, b.mispredict_count, b.IF_predict_taken);
      end
    end
    @(negedge clk);
    drive_branch(32'h0040_0010, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (b.redirect_kind !== 2'b11 || b.IF_ID_Flush !== 1'b1 || b.ID_EX_Flush !== 1'b1) begin
      errors++; $display("FAIL stall_release got %b/%b/%b want 11/1/1",
                         b.redirect_kind, b.IF_ID_Flush, b.ID_EX_Flush);
    end
    @(negedge clk);
    b.EX_Branch = 0;
    #1;
    checks++;
    if (b.branch_count !== 16'd5 || b.mispredict_count !== 16'd3 || b.IF_predict_taken !== 1'b0) begin
      errors++; $display("FAIL stall_after got %0d/%0d/%b want 5/3/0",
                         b.branch_count, b.mispredict_count, b.IF_predict_taken);
    end
    // The counter should be 01 after one decrement. It would be 00 after two.
    // A taken branch then gives 10 (prediction 1) only in the single-update case.
    @(negedge clk);
    drive_branch(32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    b.EX_Branch = 0;
    #1;
    checks++;
    if (b.branch_count !== 16'd6 || b.mispredict_count !== 16'd4 || b.IF_predict_taken !== 1'b1) begin
      errors++; $display("FAIL stall_once got %0d/%0d/%b want 6/4/1",
                         b.branch_count, b.mispredict_count, b.IF_predict_taken);
    end
  endtask

  // PCs 0x04 and 0x44 share index 1. The 4-bit branch counter holds at 15.
  task automatic test_alias_saturation();
    s.IF_PC = 32'h0000_0044;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s.EX_Branch = 1; s.EX_PC = (i % 2 == 0) ? 32'h0000_0004 : 32'h0000_0044;
      s.EX_taken = 1; s.EX_pred_taken = 1;
      if (i == 1) begin
        // one taken update from 0x04 already moved the shared entry 01->10
        #1;
        checks++;
        if (s.IF_predict_taken !== 1'b1) begin
          errors++; $display("FAIL alias_shared got %b want 1", s.IF_predict_taken);
        end
      end
      if (i == 16) begin
        #1;
        checks++;
        if (s.branch_count !== 4'd15) begin
          errors++; $display("FAIL sat_at16 got %0d want 15", s.branch_count);
        end
      end
    end
    @(negedge clk);
    s.EX_Branch = 0;
    #1;
    checks++;
    if (s.branch_count !== 4'd15 || s.mispredict_count !== 4'd0 || s.IF_predict_taken !== 1'b1) begin
      errors++; $display("FAIL sat_final got %0d/%0d/%b want 15/0/1",
                         s.branch_count, s.mispredict_count, s.IF_predict_taken);
    end
    // A clear in the same cycle as a mispredicting branch wins.
    @(negedge clk);
    s.EX_Branch = 1; s.EX_PC = 32'h0000_0004; s.EX_taken = 0; s.EX_pred_taken = 1; s.clear_stats = 1;
    @(negedge clk);
    s.EX_Branch = 0; s.clear_stats = 0;
    #1;
    checks++;
    if (s.branch_count !== 4'd0 || s.mispredict_count !== 4'd0) begin
      errors++; $display("FAIL clear_priority got %0d/%0d want 0/0", s.branch_count, s.mispredict_count);
    end
    @(negedge clk);
    s.EX_Branch = 1; s.EX_PC = 32'h0000_0044; s.EX_taken = 0; s.EX_pred_taken = 1;
    @(negedge clk);
    s.EX_Branch = 0;
    #1;
    checks++;
    if (s.branch_count !== 4'd1 || s.mispredict_count !== 4'd1) begin
      errors++; $display("FAIL after_clear got %0d/%0d want 1/1", s.branch_count, s.mispredict_count);
    end
  endtask

  // Reset asserted mid-run restores the statistics and the table at once.
  task automatic test_reset_mid_run();
    @(negedge clk);
    reset_n = 0;
    #1;
    checks++;
    if (b.branch_count !== 16'd0 || b.mispredict_count !== 16'd0) begin
      errors++; $display("FAIL midreset_counts got %0d/%0d want 0/0", b.branch_count, b.mispredict_count);
    end
    b.IF_PC = 32'h0040_0010;
    #1;
    checks++;
    if (b.IF_predict_taken !== 1'b0) begin
      errors++; $display("FAIL midreset_table got %b want 0", b.IF_predict_taken);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mispredict_train();
    test_jump_during_mispredict();
    test_jump_alone();
    test_stall();
    test_alias_saturation();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_hazard_unit.md
Name: branch_predict_hazard_unit

Overview:
- Successor to the fixed jump/branch flush logic.
- Adds a parametrised bimodal branch history table (BHT) of saturating counters, read in IF to supply a taken prediction and updated when a branch resolves in EX.
- Flushes only on a misprediction or an ID-stage jump, and reports a redirect kind to the PC mux.
- Keeps saturating branch and mispredict statistics counters; sits beside the hazard/forwarding units in PipelineCPU.

Parameters:
- PC_WIDTH, 32, width of program-counter inputs.
- BHT_ENTRIES, 16, number of BHT entries; power of two, at least 2. IDX_W = clog2(BHT_ENTRIES).
- BHT_INDEX_LSB, 2, lowest PC bit used for the index; index = PC[BHT_INDEX_LSB +: IDX_W].
- COUNTER_WIDTH, 2, bits per saturating counter; at least 1. Prediction = counter MSB.
- COUNTER_INIT, 1, reset value of every counter (weakly not-taken at width 2).
- PERF_WIDTH, 16, width of the statistics counters.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- stall, input, 1, pipeline freeze (load-use); when 1, no update, no count, no flush, no redirect.
- clear_stats, input, 1, synchronous clear of both statistics counters.
- IF_PC, input, PC_WIDTH, PC of the instruction being fetched; BHT lookup address.
- IF_predict_taken, output, 1, combinational prediction for IF_PC.
- ID_Jump, input, 1, jump decoded in ID.
- EX_Branch, input, 1, a conditional branch is in EX.
- EX_PC, input, PC_WIDTH, PC of the EX-stage branch.
- EX_taken, input, 1, resolved branch outcome.
- EX_pred_taken, input, 1, prediction carried down the pipeline with the branch.
- IF_ID_Flush, output, 1, clear the IF/ID register.
- ID_EX_Flush, output, 1, clear the ID/EX register.
- redirect_kind, output, 2, PC source select:
  - 00 = none.
  - 01 = jump target.
  - 10 = mispredict, go to branch target.
  - 11 = mispredict, go to EX_PC+4.
- branch_count, output, PERF_WIDTH, branches resolved.
- mispredict_count, output, PERF_WIDTH, mispredictions.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All BHT counters load COUNTER_INIT.
  - branch_count and mispredict_count go to 0.
  - Flush and redirect outputs are functions of inputs and are gated by stall only.
- Lookup:
  - IF_predict_taken = MSB of BHT[IF_PC index].
  - Combinational, zero latency.
  - Read-during-write to the same index returns the pre-update value; the new value is visible the next cycle.
- Mispredict:
  - mis = EX_Branch && !stall && (EX_taken != EX_pred_taken).
- Outputs, in priority order:
  - If mis: IF_ID_Flush=1, ID_EX_Flush=1, redirect_kind = EX_taken ? 10 : 11.
    - Any simultaneous ID_Jump is wrong-path and is ignored.
  - Else if ID_Jump && !stall: IF_ID_Flush=1, ID_EX_Flush=0, redirect_kind=01.
  - Else: all flush outputs 0, redirect_kind=00.
  - A correctly predicted branch causes no flush.
- BHT update, on the clock edge when EX_Branch && !stall:
  - Entry at the EX_PC index increments if EX_taken, else decrements.
  - Saturates at 0 and at 2^COUNTER_WIDTH-1.
  - Only one entry updates per cycle.
  - A stalled EX branch updates exactly once, in its first non-stalled cycle.
- Statistics, on the clock edge:
  - clear_stats=1 sets both counters to 0 and has priority over increments in the same cycle.
  - Otherwise, if EX_Branch && !stall, branch_count increments; if mis, mispredict_count also increments.
  - Both counters saturate at all-ones; no wrap.
- Aliasing: PCs with equal index bits share an entry; this is intended, and no tag is kept.
- Reset mid-operation: BHT and statistics revert immediately; outputs follow the current inputs.
- X-safety: when EX_Branch=0, EX_PC, EX_taken and EX_pred_taken are don't-care and have no effect.

Test Plan:
- Reset, then IF_PC=0x0040_0000 -> IF_predict_taken=0; all counters 0; redirect_kind=00.
- Branch at EX_PC=0x0040_0010 with EX_pred_taken=0, EX_taken=1, for three cycles, feeding back IF_predict_taken:
  - Cycle 1: flushes 1/1, redirect_kind=10, counter 01->10.
  - Cycles 2-3: no flush, counter saturates at 11.
  - branch_count=3, mispredict_count=1.
- ID_Jump=1 in the same cycle as an EX mispredict (EX_taken=0, EX_pred_taken=1) -> redirect_kind=11, both flushes 1, jump ignored.
- ID_Jump=1 alone -> IF_ID_Flush=1, ID_EX_Flush=0, redirect_kind=01, statistics unchanged.
- stall=1 for 2 cycles with an EX mispredict present, then stall=0:
  - Stalled cycles: no flush, no update.
  - First non-stalled cycle: exactly one update and branch_count+1.
- Aliasing and saturation: with PERF_WIDTH=4, run 20 branches at 0x0000_0004 and 0x0000_0044 (same index):
  - Shared counter moves as one entry.
  - branch_count holds at 15.
  - clear_stats during an increment -> 0.
